// File: rtl/draw_scheduler.sv
// Purpose : per-frame sequencer that shares the VGA plot path between the ball, brick and platform drawers.
// Latency : go reaches the first drawer 2 cycles after frame_tick. Each later slot starts 2 cycles after its predecessor's done.
// Backpressure: a drawer holds its slot until it pulses done. A frame_tick that arrives while busy is dropped and flagged on overrun.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   frame_tick          one-cycle frame start pulse
//   client_en[2:0]      drawer enables (0 ball, 1 bricks, 2 plat), sampled at the start of each pass
//   done[2:0]           one-hot completion pulses from the drawers
//   go[2:0]             one-cycle one-hot start pulse to the selected drawer
//   sel[1:0]            draw_mux select; holds its last value while idle
//   iscolour            0 = erase (black) pass, 1 = colour pass
//   inc_enable          one-cycle position-update strobe between the two passes
//   busy                high whenever the sequencer is not idle
//   overrun             one-cycle pulse when a frame_tick is dropped
//   timeout_err[2:0]    sticky per-drawer watchdog flags
//
// Build option: define DRAW_TIMEOUT_EN to add the WAIT watchdog (TIMEOUT cycles, CW-bit counter).
// Without it a drawer may hold WAIT forever and timeout_err is tied low.
module draw_scheduler #(
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] client_en,
  input  logic [2:0] done,
  output logic [2:0] go,
  output logic [1:0] sel,
  output logic       iscolour,
  output logic       inc_enable,
  output logic       busy,
  output logic       overrun,
  output logic [2:0] timeout_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN     = 3'd1;
  localparam logic [2:0] S_GO       = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_END_PASS = 3'd4;

  // The watchdog counter must be able to reach TIMEOUT.
  if (TIMEOUT < 1 || TIMEOUT >= (1 << CW)) begin : g_timeout_range
    $error("draw_scheduler: TIMEOUT must lie in 1 .. 2**CW-1");
  end

  logic [2:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       iscolour_q, iscolour_d;
  logic [2:0] mask_q, mask_d;

  logic [2:0] sel_oh;
  logic       done_sel;
  logic       wd_fire;
  logic       slot_done;

  // One-hot form of sel; sel never takes the value 3.
  always_comb begin
    sel_oh = 3'b000;
    case (sel_q)
      2'd0:    sel_oh = 3'b001;
      2'd1:    sel_oh = 3'b010;
      default: sel_oh = 3'b100;
    endcase
  end

  // Only the done bit of the drawer that owns the slot counts.
  assign done_sel  = |(done & sel_oh);
  assign slot_done = done_sel | wd_fire;

`ifdef DRAW_TIMEOUT_EN
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic [CW-1:0] wd_cnt_inc;
  logic [2:0]    timeout_err_q, timeout_err_d;

  // wd_cnt_inc is the number of WAIT cycles including the current one,
  // so the slot is retired at the end of the TIMEOUT-th WAIT cycle.
  assign wd_cnt_inc = wd_cnt_q + 1'b1;
  assign wd_fire    = (state_q == S_WAIT) && (wd_cnt_inc == CW'(TIMEOUT));

  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == S_GO) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_inc;
    end
    if (wd_fire && !done_sel) begin
      timeout_err_d = timeout_err_q | sel_oh;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 3'b000;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 3'b000;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    iscolour_d = iscolour_q;
    mask_d     = mask_q;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          mask_d     = client_en;
          iscolour_d = 1'b0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        // Lowest enabled drawer first: ball, bricks, plat.
        if (mask_q[0]) begin
          sel_d     = 2'd0;
          mask_d[0] = 1'b0;
          state_d   = S_GO;
        end else if (mask_q[1]) begin
          sel_d     = 2'd1;
          mask_d[1] = 1'b0;
          state_d   = S_GO;
        end else if (mask_q[2]) begin
          sel_d     = 2'd2;
          mask_d[2] = 1'b0;
          state_d   = S_GO;
        end else begin
          state_d = S_END_PASS;
        end
      end
      S_GO: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (slot_done) begin
          state_d = S_SCAN;
        end
      end
      S_END_PASS: begin
        if (!iscolour_q) begin
          iscolour_d = 1'b1;
          mask_d     = client_en;
          state_d    = S_SCAN;
        end else begin
          iscolour_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'd0;
      iscolour_q <= 1'b0;
      mask_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      iscolour_q <= iscolour_d;
      mask_q     <= mask_d;
    end
  end

  assign go         = (state_q == S_GO) ? sel_oh : 3'b000;
  assign sel        = sel_q;
  assign iscolour   = iscolour_q;
  assign inc_enable = (state_q == S_END_PASS) && !iscolour_q;
  assign busy       = (state_q != S_IDLE);
  // Covers the END_PASS cycle that returns to IDLE: that tick is lost too.
  assign overrun    = frame_tick && (state_q != S_IDLE);

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic [2:0] client_en;
  logic [2:0] done;
  logic [2:0] done_auto;
  logic [2:0] done_man;
  logic [2:0] go;
  logic [1:0] sel;
  logic       iscolour;
  logic       inc_enable;
  logic       busy;
  logic       overrun;
  logic [2:0] timeout_err;

  // Drawer model controls, written only by the main sequence.
  int         dly;
  logic [2:0] mute;

  // Monitor records, written only by the monitor.
  logic [2:0] go_log[$];
  logic       col_log[$];
  int         inc_total;
  int         busy_total;
  int         ovr_total;
  int         sel1_total;

  int n_vec;
  int n_bad;

  assign done = done_auto | done_man;

  draw_scheduler #(.TIMEOUT(15), .CW(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .client_en   (client_en),
    .done        (done),
    .go          (go),
    .sel         (sel),
    .iscolour    (iscolour),
    .inc_enable  (inc_enable),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called in the idle cycle before E0; returns in the cycle after E0.
  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) return;
      step();
    end
    check_val("idle_budget", int'(busy), 0);
  endtask

  // Drawer model: a drawer that received go pulses done dly cycles later
  // (dly=1 means in the first WAIT cycle) unless its bit is muted.
  initial begin
    int         pend;
    logic [2:0] pbit;
    pend      = 0;
    pbit      = 3'b000;
    done_auto = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      done_auto = 3'b000;
      if (go != 3'b000) begin
        if ((go & mute) == 3'b000) begin
          pend = dly;
          pbit = go;
        end else begin
          pend = 0;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) done_auto = pbit;
      end
    end
  end

  // Monitor: samples outputs mid-cycle.
  initial begin
    inc_total  = 0;
    busy_total = 0;
    ovr_total  = 0;
    sel1_total = 0;
    forever begin
      @(negedge clk);
      if (go != 3'b000) begin
        go_log.push_back(go);
        col_log.push_back(iscolour);
      end
      if (inc_enable) inc_total++;
      if (busy) busy_total++;
      if (overrun) ovr_total++;
      if (busy && sel == 2'd1) sel1_total++;
    end
  end

  initial begin
    #400000;
    $display("FAIL sim_time_limit got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int gb, ib, bb, ob, sb;
    n_vec      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    frame_tick = 1'b0;
    client_en  = 3'b000;
    done_man   = 3'b000;
    dly        = 1;
    mute       = 3'b000;

    // Reset state
    steps(2);
    check_val("rst_go", int'(go), 0);
    check_val("rst_sel", int'(sel), 0);
    check_val("rst_iscolour", int'(iscolour), 0);
    check_val("rst_inc", int'(inc_enable), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_overrun", int'(overrun), 0);
    check_val("rst_timeout_err", int'(timeout_err), 0);
    reset = 1'b0;
    steps(2);

    // All three drawers, done 5 cycles after go
    client_en = 3'b111;
    dly = 5;
    gb = go_log.size(); ib = inc_total; bb = busy_total; ob = ovr_total;
    pulse_tick();
    check_val("all_c1_busy", int'(busy), 1);
    check_val("all_c1_go", int'(go), 0);
    step();
    check_val("all_c2_go", int'(go), 1);
    check_val("all_c2_iscolour", int'(iscolour), 0);
    wait_idle(200);
    check_val("all_go_count", go_log.size() - gb, 6);
    for (int i = 0; i < 6; i++) begin
      int exp_go;
      exp_go = 1 << (i % 3);
      check_val($sformatf("all_go_%0d", i), int'(go_log[gb + i]), exp_go);
      check_val($sformatf("all_col_%0d", i), int'(col_log[gb + i]), (i < 3) ? 0 : 1);
    end
    check_val("all_inc", inc_total - ib, 1);
    check_val("all_busy_cycles", busy_total - bb, 46);
    check_val("all_overrun", ovr_total - ob, 0);
    step();

    // Subset mask: ball and plat only
    client_en = 3'b101;
    dly = 1;
    gb = go_log.size(); ib = inc_total; bb = busy_total; sb = sel1_total;
    pulse_tick();
    wait_idle(100);
    check_val("sub_go_count", go_log.size() - gb, 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("sub_go_%0d", i), int'(go_log[gb + i]), (i % 2 == 0) ? 1 : 4);
    end
    check_val("sub_sel1", sel1_total - sb, 0);
    check_val("sub_busy_cycles", busy_total - bb, 16);
    check_val("sub_inc", inc_total - ib, 1);
    step();

    // Empty mask
    client_en = 3'b000;
    gb = go_log.size(); ib = inc_total; bb = busy_total;
    pulse_tick();
    wait_idle(50);
    check_val("empty_go_count", go_log.size() - gb, 0);
    check_val("empty_inc", inc_total - ib, 1);
    check_val("empty_busy_cycles", busy_total - bb, 4);
    step();

    // Overrun: tick during ball WAIT (c4) and on the final END_PASS (c18)
    client_en = 3'b001;
    dly = 5;
    gb = go_log.size(); ib = inc_total; bb = busy_total; ob = ovr_total;
    pulse_tick();
    steps(3);
    frame_tick = 1'b1;
    #1;
    check_val("ovr_wait_pulse", int'(overrun), 1);
    step();
    frame_tick = 1'b0;
    steps(13);
    check_val("ovr_end_iscolour", int'(iscolour), 1);
    frame_tick = 1'b1;
    #1;
    check_val("ovr_end_pulse", int'(overrun), 1);
    step();
    frame_tick = 1'b0;
    check_val("ovr_after_busy", int'(busy), 0);
    steps(5);
    check_val("ovr_still_idle", int'(busy), 0);
    check_val("ovr_count", ovr_total - ob, 2);
    check_val("ovr_inc", inc_total - ib, 1);
    check_val("ovr_go_count", go_log.size() - gb, 2);
    check_val("ovr_busy_cycles", busy_total - bb, 18);

    // Misdirected done in ball WAIT
    client_en = 3'b001;
    dly = 1;
    mute = 3'b001;
    gb = go_log.size();
    pulse_tick();
    steps(2);
    done_man = 3'b010;
    step();
    done_man = 3'b000;
    step();
    check_val("mis_c5_inc", int'(inc_enable), 0);
    check_val("mis_c5_busy", int'(busy), 1);
    step();
    done_man = 3'b001;
    step();
    done_man = 3'b000;
    mute = 3'b000;
    step();
    check_val("mis_c8_inc", int'(inc_enable), 1);
    wait_idle(50);
    check_val("mis_go_count", go_log.size() - gb, 2);
    step();

    // Watchdog: bricks never answers
    client_en = 3'b111;
    dly = 1;
    mute = 3'b010;
    pulse_tick();
    steps(4);
    check_val("wd_bricks_go", int'(go), 2);
    steps(15);
    check_val("wd_c20_busy", int'(busy), 1);
    check_val("wd_c20_err", int'(timeout_err), 0);
    check_val("wd_c20_go", int'(go), 0);
    step();
`ifdef DRAW_TIMEOUT_EN
    check_val("wd_c21_err", int'(timeout_err), 2);
    step();
    check_val("wd_c22_plat_go", int'(go), 4);
`else
    check_val("wd_c21_err", int'(timeout_err), 0);
    step();
    check_val("wd_c22_go", int'(go), 0);
    steps(18);
    check_val("wd_hold_go", int'(go), 0);
    check_val("wd_hold_busy", int'(busy), 1);
    check_val("wd_hold_err", int'(timeout_err), 0);
    done_man = 3'b010;
    step();
    done_man = 3'b000;
    step();
    check_val("wd_manual_plat_go", int'(go), 4);
`endif
    mute = 3'b000;
    wait_idle(300);
    step();
    pulse_tick();
`ifdef DRAW_TIMEOUT_EN
    check_val("wd_sticky_err", int'(timeout_err), 2);
`else
    check_val("wd_sticky_err", int'(timeout_err), 0);
`endif
    wait_idle(300);
    step();

    // Reset mid-WAIT in the colour pass (plat only, done after 8)
    client_en = 3'b100;
    dly = 8;
    pulse_tick();
    steps(15);
    check_val("rmw_sel", int'(sel), 2);
    check_val("rmw_iscolour", int'(iscolour), 1);
    check_val("rmw_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_val("rmw_go", int'(go), 0);
    check_val("rmw_sel0", int'(sel), 0);
    check_val("rmw_iscolour0", int'(iscolour), 0);
    check_val("rmw_inc", int'(inc_enable), 0);
    check_val("rmw_busy0", int'(busy), 0);
    check_val("rmw_overrun", int'(overrun), 0);
    check_val("rmw_err", int'(timeout_err), 0);
    step();
    reset = 1'b0;
    steps(20);
    dly = 1;
    gb = go_log.size(); ib = inc_total;
    pulse_tick();
    step();
    check_val("rmw_new_go", int'(go), 4);
    check_val("rmw_new_iscolour", int'(iscolour), 0);
    wait_idle(50);
    check_val("rmw_new_go_count", go_log.size() - gb, 2);
    check_val("rmw_new_inc", inc_total - ib, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
